eth_tx_framer: RTL

//  Generic GMII transmit framer that replaces hard-coded, counter-driven frame senders.

---
 rtl/eth_tx_framer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD, streamed frame bytes, optional zero pad, CRC-32 FCS, inter-frame gap.
// Define ETH_TX_AUTOPAD_EN to compile in the PAD state that zero-pads short frames to MIN_FRAME.
module eth_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int MAX_FRAME    = 1514,
  parameter int IFG_LEN      = 12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
`ifdef ETH_TX_AUTOPAD_EN
    PAD,
`endif
    FCS,
    IFG,
    DROP
  } state_t;

  localparam logic [10:0] MIN_W    = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_W    = 11'(MAX_FRAME);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  // The IDLE cycle before the next preamble supplies the last gap cycle.
  localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 2);
  localparam state_t      GAP_STATE = (IFG_LEN > 1) ? IFG : IDLE;
`ifdef ETH_TX_AUTOPAD_EN
  localparam state_t      SHORT_NEXT = PAD;
`else
  localparam state_t      SHORT_NEXT = FCS;
`endif

  state_t      state_q, state_d;
  logic [15:0] phase_q, phase_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_er_q, tx_er_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_abort_q, frame_abort_d;
  logic [10:0] byte_cnt_inc;
  logic [31:0] crc_inv;

  // Reflected CRC-32 (0x04C11DB7 reversed), one byte per call, LSB first.
  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign crc_inv      = ~crc_q;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    byte_cnt_d    = byte_cnt_q;
    crc_d         = crc_q;
    tx_en_d       = 1'b0;
    tx_data_d     = 8'h00;
    tx_er_d       = 1'b0;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d    = PRE;
          phase_d    = 16'd0;
          byte_cnt_d = 11'd0;
          crc_d      = 32'hFFFF_FFFF;
        end
      end
      PRE: begin
        tx_en_d   = 1'b1;
        tx_data_d = 8'h55;
        if (phase_q == PRE_LAST) begin
          state_d = SFD;
          phase_d = 16'd0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      SFD: begin
        tx_en_d   = 1'b1;
        tx_data_d = 8'hD5;
        state_d   = DATA;
      end
      DATA: begin
        tx_en_d = 1'b1;
        phase_d = 16'd0;
        if (!s_valid) begin
          // The PHY stream cannot stall: poison the frame and discard the rest.
          tx_er_d       = 1'b1;
          frame_abort_d = 1'b1;
          state_d       = DROP;
        end else if (byte_cnt_q >= MAX_W) begin
          tx_er_d       = 1'b1;
          frame_abort_d = 1'b1;
          state_d       = s_last ? GAP_STATE : DROP;
        end else begin
          tx_data_d  = s_data;
          crc_d      = crc_next(crc_q, s_data);
          byte_cnt_d = byte_cnt_inc;
          if (s_last) begin
            state_d = (byte_cnt_inc < MIN_W) ? SHORT_NEXT : FCS;
          end
        end
      end
`ifdef ETH_TX_AUTOPAD_EN
      PAD: begin
        tx_en_d    = 1'b1;
        crc_d      = crc_next(crc_q, 8'h00);
        byte_cnt_d = byte_cnt_inc;
        phase_d    = 16'd0;
        if (byte_cnt_inc >= MIN_W) begin
          state_d = FCS;
        end
      end
`endif
      FCS: begin
        tx_en_d   = 1'b1;
        tx_data_d = crc_inv[{phase_q[1:0], 3'b000} +: 8];
        if (phase_q[1:0] == 2'd3) begin
          frame_done_d = 1'b1;
          state_d      = GAP_STATE;
          phase_d      = 16'd0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      IFG: begin
        if (phase_q == IFG_LAST) begin
          state_d = IDLE;
          phase_d = 16'd0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      DROP: begin
        if (s_valid && s_last) begin
          state_d = GAP_STATE;
          phase_d = 16'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      phase_q       <= 16'd0;
      byte_cnt_q    <= 11'd0;
      crc_q         <= 32'hFFFF_FFFF;
      tx_en_q       <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_er_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      byte_cnt_q    <= byte_cnt_d;
      crc_q         <= crc_d;
      tx_en_q       <= tx_en_d;
      tx_data_q     <= tx_data_d;
      tx_er_q       <= tx_er_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign s_ready     = (state_q == DATA) || (state_q == DROP);
  assign busy        = (state_q != IDLE);
  assign tx_en       = tx_en_q;
  assign tx_data     = tx_data_q;
  assign tx_er       = tx_er_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule
